// File: rtl/mantissa_sub_norm.sv
// rtl/mantissa_sub_norm.sv - chunk-serial |A-B| with dual borrow chains and one-bit-per-cycle left normalization
module mantissa_sub_norm #(
    parameter int sizeCSA = 22,
    parameter int sizeRCA = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [sizeCSA-1:0]           A,
    input  logic [sizeCSA-1:0]           B,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [sizeCSA-1:0]           D,
    output logic                         Sign_o,
    output logic [$clog2(sizeCSA+1)-1:0] Shift_o,
    output logic                         Zero_o
);
    localparam int W  = sizeCSA;
    localparam int R  = sizeRCA;
    localparam int N  = (W + R - 1) / R;
    localparam int NR = N * R;
    localparam int SW = $clog2(W + 1);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SUB, NORM, DONE} state_t;

    state_t        state;
    logic [NR-1:0] a_sh, b_sh, dab, dba;
    logic          bab, bba;
    logic [KW-1:0] k;
    logic [R:0]    sub_ab, sub_ba;
    logic [NR-1:0] dab_nxt, dba_nxt;

    assign ready_o = (state == IDLE);

    // Operands shift down one chunk per cycle; the top bit of each R+1-bit result is the outgoing borrow.
    always_comb begin
        sub_ab  = {1'b0, a_sh[R-1:0]} - {1'b0, b_sh[R-1:0]} - {{R{1'b0}}, bab};
        sub_ba  = {1'b0, b_sh[R-1:0]} - {1'b0, a_sh[R-1:0]} - {{R{1'b0}}, bba};
        dab_nxt = {sub_ab[R-1:0], dab[NR-1:R]};
        dba_nxt = {sub_ba[R-1:0], dba[NR-1:R]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            D       <= '0;
            Sign_o  <= 1'b0;
            Shift_o <= '0;
            Zero_o  <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            dab     <= '0;
            dba     <= '0;
            bab     <= 1'b0;
            bba     <= 1'b0;
            k       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        a_sh    <= NR'(A);
                        b_sh    <= NR'(B);
                        bab     <= 1'b0;
                        bba     <= 1'b0;
                        k       <= '0;
                        Shift_o <= '0;
                        Zero_o  <= 1'b0;
                        state   <= SUB;
                    end
                end
                SUB: begin
                    a_sh <= a_sh >> R;
                    b_sh <= b_sh >> R;
                    dab  <= dab_nxt;
                    dba  <= dba_nxt;
                    bab  <= sub_ab[R];
                    bba  <= sub_ba[R];
                    k    <= k + 1'b1;
                    if (k == KW'(N - 1)) begin
                        // A final borrow out of A-B means B>A, so the B-A chain holds the magnitude.
                        D      <= sub_ab[R] ? dba_nxt[W-1:0] : dab_nxt[W-1:0];
                        Sign_o <= sub_ab[R];
                        state  <= NORM;
                    end
                end
                NORM: begin
                    if (D == '0) begin
                        Zero_o  <= 1'b1;
                        Shift_o <= SW'(W);
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end else if (D[W-1]) begin
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end else begin
                        D       <= D << 1;
                        Shift_o <= Shift_o + 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mantissa_sub_norm.sv
// tb/tb_mantissa_sub_norm.sv - randomized self-checking bench against an arithmetic reference model
module tb_mantissa_sub_norm;
    localparam int W  = 22;
    localparam int N  = 6;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [W-1:0]  D;
    logic          Sign_o;
    logic [SW-1:0] Shift_o;
    logic          Zero_o;

    int checks = 0;
    int errors = 0;

    mantissa_sub_norm #(.sizeCSA(W), .sizeRCA(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .A(A), .B(B), .valid_o(valid_o), .ready_i(ready_i),
        .D(D), .Sign_o(Sign_o), .Shift_o(Shift_o), .Zero_o(Zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: magnitude, sign, leading-zero count and latency from plain arithmetic.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] d, output logic sg, output int sh,
                         output logic z, output int lat);
        int unsigned mag;
        sg  = (b > a);
        mag = sg ? (int'(b) - int'(a)) : (int'(a) - int'(b));
        z   = (mag == 0);
        sh  = 0;
        if (z) begin
            sh = W;
            d  = '0;
        end else begin
            while (((mag << sh) & (1 << (W - 1))) == 0) sh++;
            d = W'(mag << sh);
        end
        lat = N + 2 + (z ? 0 : sh);
    endtask

    task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold);
        logic [W-1:0] ed;
        logic         es, ez;
        int           esh, elat, lat;
        logic [W-1:0] d_hold;
        model(a, b, ed, es, esh, ez, elat);
        check({tag, "_ready_before"}, 32'(ready_o), 32'd1);
        A = a;
        B = b;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        lat = 1;
        while (!valid_o && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_D"}, 32'(D), 32'(ed));
        check({tag, "_sign"}, 32'(Sign_o), 32'(es));
        check({tag, "_shift"}, 32'(Shift_o), 32'(esh));
        check({tag, "_zero"}, 32'(Zero_o), 32'(ez));
        d_hold = D;
        for (int i = 0; i < hold; i++) begin
            valid_i = (i == 1);
            A = W'($urandom);
            B = W'($urandom);
            tick();
            check({tag, "_bp_valid"}, 32'(valid_o), 32'd1);
            check({tag, "_bp_ready"}, 32'(ready_o), 32'd0);
            check({tag, "_bp_D"}, 32'(D), 32'(d_hold));
        end
        valid_i = 1'b0;
        if (hold > 0) check({tag, "_bp_shift"}, 32'(Shift_o), 32'(esh));
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check({tag, "_post_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_post_ready"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           seen;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            A = W'($urandom);
            B = W'($urandom);
            ready_i = 1'($urandom);
            tick();
            check("rst_valid", 32'(valid_o), 32'd0);
            check("rst_D", 32'(D), 32'd0);
            check("rst_sign", 32'(Sign_o), 32'd0);
            check("rst_shift", 32'(Shift_o), 32'd0);
            check("rst_zero", 32'(Zero_o), 32'd0);
            check("rst_ready", 32'(ready_o), 32'd1);
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(ready_o), 32'd1);
        check("post_rst_valid", 32'(valid_o), 32'd0);

        run_txn("pos", 22'h200000, 22'h000001, 0);
        run_txn("neg", 22'h000001, 22'h200000, 0);
        run_txn("eq", 22'h012345, 22'h012345, 0);
        run_txn("maxshift", 22'h000003, 22'h000002, 5);

        // Abandon a transaction in SUB and confirm no result ever appears.
        A = 22'h3FFFFF;
        B = 22'h000000;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", 32'(ready_o), 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (valid_o) seen++;
            tick();
        end
        check("midrst_no_valid", 32'(seen), 32'd0);
        run_txn("after_rst", 22'h3FFFFF, 22'h000000, 0);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = W'($urandom);
                1: rb = ra ^ W'($urandom_range(0, 15));
                2: rb = ra;
                default: rb = W'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 1) == 1) run_txn("rand", rb, ra, $urandom_range(0, 3));
            else run_txn("rand", ra, rb, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
